// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcode, ALU and state encodings for the multicycle controller
// MC_ILLEGAL_TRAP_EN adds the HALT state to the state enum.
package mc_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU control decode from aluop and funct
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle datapath
// MC_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT and raise illegal.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] op,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t     state, next_state;
  logic       pcwrite, branch, mw, irw, rw;
  logic [1:0] aluop;
  logic [2:0] alu_dec;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       halted;
`endif

  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
    halted     = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irw     = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b10;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      next_state = S_HALT;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw         = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        next_state = S_FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT: begin
        halted = 1'b1;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // Gating with rst_n kills enables combinationally, so an abort never leaves a partial write.
  assign pcen       = rst_n & (pcwrite | (branch & zero));
  assign memwrite   = rst_n & mw;
  assign irwrite    = rst_n & irw;
  assign regwrite   = rst_n & rw;
  assign alucontrol = rst_n ? alu_dec : ALU_ADD;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal    = rst_n & halted;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller; honours MC_ILLEGAL_TRAP_EN
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op;
  logic [2:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [15:0] obs;
  int total = 0;
  int bad   = 0;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // {pcen,memwrite,irwrite,regwrite, iord,memtoreg,regdst,alusrca, alusrcb, pcsrc, alucontrol, illegal}
  assign obs = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};

  localparam logic [15:0] V_RESET   = 16'b0000_0000_01_00_010_0;
  localparam logic [15:0] V_FETCH   = 16'b1010_0000_01_00_010_0;
  localparam logic [15:0] V_FWAIT   = 16'b0000_0000_01_00_010_0;
  localparam logic [15:0] V_DECODE  = 16'b0000_0000_10_00_010_0;
  localparam logic [15:0] V_ALUWB   = 16'b0001_0010_00_00_010_0;
  localparam logic [15:0] V_MEMADR  = 16'b0000_0001_10_00_010_0;
  localparam logic [15:0] V_MEMRD   = 16'b0000_1000_00_00_010_0;
  localparam logic [15:0] V_MEMWB   = 16'b0001_0100_00_00_010_0;
  localparam logic [15:0] V_MEMWR   = 16'b0100_1000_00_00_010_0;
  localparam logic [15:0] V_BRTAKEN = 16'b1000_0001_00_01_110_0;
  localparam logic [15:0] V_BRNOT   = 16'b0000_0001_00_01_110_0;
  localparam logic [15:0] V_ADDIWB  = 16'b0001_0000_00_00_010_0;
  localparam logic [15:0] V_JUMP    = 16'b1000_0000_00_10_010_0;
  localparam logic [15:0] V_HALT    = 16'b0000_0000_00_00_010_1;

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs for the current state, check outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] o, input logic [2:0] f,
                     input logic z, input logic mr, input logic [15:0] exp);
    op = o; funct = f; zero = z; mem_ready = mr;
    #1;
    chk(tag, exp);
    @(posedge clk);
    #2;
  endtask

  logic [2:0] fv [6];
  logic [2:0] av [6];

  initial begin
    fv = '{3'b010, 3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    av = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b111, 3'b010};

    rst_n = 1'b0; op = 4'b0000; funct = 3'b010; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("reset_a", V_RESET);
    @(posedge clk); #2;
    chk("reset_b", V_RESET);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc("r_fetch",  4'b0000, fv[i], 1'b0, 1'b1, V_FETCH);
      cyc("r_decode", 4'b0000, fv[i], 1'b0, 1'b1, V_DECODE);
      cyc("r_exec",   4'b0000, fv[i], 1'b0, 1'b1, {12'b0000_0001_00_00, av[i], 1'b0});
      cyc("r_aluwb",  4'b0000, fv[i], 1'b0, 1'b1, V_ALUWB);
    end

    cyc("lw_fetch",  4'b0001, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("lw_decode", 4'b0001, 3'b000, 1'b0, 1'b1, V_DECODE);
    cyc("lw_memadr", 4'b0001, 3'b000, 1'b0, 1'b1, V_MEMADR);
    cyc("lw_memrd0", 4'b0001, 3'b000, 1'b0, 1'b0, V_MEMRD);
    cyc("lw_memrd1", 4'b0001, 3'b000, 1'b0, 1'b0, V_MEMRD);
    cyc("lw_memrd2", 4'b0001, 3'b000, 1'b0, 1'b1, V_MEMRD);
    cyc("lw_memwb",  4'b0001, 3'b000, 1'b0, 1'b1, V_MEMWB);

    cyc("beq1_fetch",  4'b0011, 3'b000, 1'b1, 1'b1, V_FETCH);
    cyc("beq1_decode", 4'b0011, 3'b000, 1'b1, 1'b1, V_DECODE);
    cyc("beq1_branch", 4'b0011, 3'b000, 1'b1, 1'b0, V_BRTAKEN);
    cyc("beq0_fetch",  4'b0011, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("beq0_decode", 4'b0011, 3'b000, 1'b0, 1'b1, V_DECODE);
    cyc("beq0_branch", 4'b0011, 3'b000, 1'b0, 1'b1, V_BRNOT);

    cyc("sw_fwait",  4'b0010, 3'b000, 1'b0, 1'b0, V_FWAIT);
    cyc("sw_fetch",  4'b0010, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("sw_decode", 4'b0010, 3'b000, 1'b0, 1'b1, V_DECODE);
    cyc("sw_memadr", 4'b0010, 3'b000, 1'b0, 1'b1, V_MEMADR);
    cyc("sw_memwr0", 4'b0010, 3'b000, 1'b0, 1'b0, V_MEMWR);
    cyc("sw_memwr1", 4'b0010, 3'b000, 1'b0, 1'b1, V_MEMWR);

    cyc("addi_fetch",  4'b0100, 3'b001, 1'b0, 1'b1, V_FETCH);
    cyc("addi_decode", 4'b0100, 3'b001, 1'b0, 1'b1, V_DECODE);
    cyc("addi_ex",     4'b0100, 3'b001, 1'b0, 1'b1, V_MEMADR);
    cyc("addi_wb",     4'b0100, 3'b001, 1'b0, 1'b1, V_ADDIWB);

    cyc("j_fetch",  4'b0101, 3'b000, 1'b1, 1'b1, V_FETCH);
    cyc("j_decode", 4'b0101, 3'b000, 1'b1, 1'b1, V_DECODE);
    cyc("j_jump",   4'b0101, 3'b000, 1'b1, 1'b1, V_JUMP);

    cyc("ill_fetch",  4'b1111, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("ill_decode", 4'b1111, 3'b000, 1'b0, 1'b1, V_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("ill_halt0", 4'b1111, 3'b000, 1'b1, 1'b1, V_HALT);
    cyc("ill_halt1", 4'b0000, 3'b000, 1'b1, 1'b1, V_HALT);
    cyc("ill_halt2", 4'b0000, 3'b000, 1'b0, 1'b0, V_HALT);
    rst_n = 1'b0;
    #1;
    chk("ill_reset", V_RESET);
    @(posedge clk); #2;
    rst_n = 1'b1;
`endif
    cyc("post_ill_fetch",  4'b0101, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("post_ill_decode", 4'b0101, 3'b000, 1'b0, 1'b1, V_DECODE);
    cyc("post_ill_jump",   4'b0101, 3'b000, 1'b0, 1'b1, V_JUMP);

    cyc("abort_fetch",  4'b0010, 3'b000, 1'b0, 1'b1, V_FETCH);
    cyc("abort_decode", 4'b0010, 3'b000, 1'b0, 1'b1, V_DECODE);
    cyc("abort_memadr", 4'b0010, 3'b000, 1'b0, 1'b1, V_MEMADR);
    op = 4'b0010; mem_ready = 1'b0;
    #1;
    chk("abort_memwr", V_MEMWR);
    rst_n = 1'b0;
    #1;
    chk("abort_reset", V_RESET);
    @(posedge clk); #2;
    rst_n = 1'b1;
    cyc("abort_fwait", 4'b0000, 3'b010, 1'b0, 1'b0, V_FWAIT);
    cyc("abort_fetch2", 4'b0000, 3'b010, 1'b0, 1'b1, V_FETCH);
    cyc("abort_decode2", 4'b0000, 3'b010, 1'b0, 1'b1, V_DECODE);
    cyc("abort_exec2", 4'b0000, 3'b010, 1'b0, 1'b1, 16'b0000_0001_00_00_000_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the 4-bit-opcode MIPS-subset core: a Moore state machine that sequences the shared memory/ALU datapath across fetch, decode, execute, memory and writeback steps. It replaces the single-cycle controller in the multicycle build, driving the register enables and mux selects each cycle. It also contains ALU-control decoding and a memory wait handshake.

## Interface
- No parameters; opcode and state encodings are fixed constants in the shared package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `op` in 4: opcode field from instruction register.
- `funct` in 3: function field from instruction register.
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the access this cycle.
- `pcen` out 1: PC register enable, `pcwrite | (branch & zero)`.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register enable.
- `regwrite` out 1: register file write enable.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memtoreg` out 1: writeback select (1 = data register).
- `regdst` out 1: destination select (1 = rd).
- `alusrca` out 1: ALU A select (0 = PC, 1 = reg A).
- `alusrcb` out 2: ALU B select (00 = B, 01 = const 1, 10 = sign-ext immediate).
- `pcsrc` out 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `alucontrol` out 3: ALU operation.
- `illegal` out 1: illegal-opcode flag (see Configuration).

## Operation
- Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J. All others are illegal.
- Internal `aluop`: 00 add, 01 sub, 10 use funct.
- Funct map: 000→010 add, 001→110 sub, 010→000 and, 011→001 or, 100→111 slt. Other funct values give 010.
- States and transitions:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are asserted only when `mem_ready`=1. Go to DECODE on `mem_ready`, else stay.
  - DECODE: alusrca=0, alusrcb=10, aluop=00 (branch target to ALUOut). Next state by op: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP, illegal→FETCH (or HALT, see Configuration).
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: iord=1. Go to MEMWB on `mem_ready`, else stay.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR: iord=1, memwrite=1 held each cycle until `mem_ready`. Go to FETCH.
  - EXEC: alusrca=1, alusrcb=00, aluop=10. Go to ALUWB.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00. Go to ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from state, plus `op`/`funct` for `alucontrol` and `zero` for `pcen`.
- Reset: state=FETCH. While `rst_n`=0, all enables (`pcen`, `irwrite`, `memwrite`, `regwrite`) are forced to 0, `alucontrol`=010, `illegal`=0.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after assertion.
- Cycle counts with `mem_ready` tied high: R 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle. In other states `mem_ready` is ignored.
- `op` and `funct` are sampled from the instruction register, which is stable after FETCH.

## Configuration
- `MC_ILLEGAL_TRAP_EN`
  - Defined: an illegal op in DECODE goes to HALT. HALT drives all enables 0 and `illegal`=1, and is left only by reset.
  - Undefined: an illegal op returns to FETCH as a NOP (PC already incremented), no HALT state exists, and `illegal` is tied 0.

## Structure
- Shared package `mc_pkg`: opcode constants, `aluop` encodings, `alucontrol` encodings, state enum.
- Sub-module `mc_aludec`: combinational (`aluop`, `funct`) → `alucontrol`, reusable by the single-cycle build.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- Reset with `mem_ready`=1, release, `op`=0000, `funct`=010 → states FETCH, DECODE, EXEC, ALUWB; `alucontrol`=000 in EXEC; `regwrite`=1 with `regdst`=1 in cycle 4.
- LW (`op`=0001) with `mem_ready` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles, `regwrite`/`memtoreg`=1 once, total 7 cycles.
- BEQ with `zero`=1 → `pcen`=1, `pcsrc`=01, `alucontrol`=110 in BRANCH. With `zero`=0 → `pcen`=0.
- SW with `mem_ready`=0 on the first FETCH cycle → `irwrite`=0 that cycle. Later, `memwrite`=1 in MEMWR, `regwrite` never asserted.
- `op`=1111 → with the macro, HALT and `illegal`=1 until reset. Without it, FETCH follows DECODE.
- `rst_n` asserted during MEMWR → `memwrite` drops asynchronously, state=FETCH.
